// File: rtl/gpu_opcode_collector_if.sv
// rtl/gpu_opcode_collector_if.sv - beat-in / opcode-out handshake bundle for gpu_opcode_collector
interface gpu_opcode_collector_if #(
  parameter int BEAT_W   = 4,
  parameter int OPCODE_W = 16,
  parameter int DEPTH    = 4
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic                in_valid;
  logic                in_ready;
  logic [BEAT_W-1:0]   in_beat;
  logic                out_valid;
  logic                out_ready;
  logic [OPCODE_W-1:0] out_opcode;
  logic [LVL_W-1:0]    level;
  logic                partial;
  logic                err_overflow;

  modport master (
    output in_valid, in_beat, out_ready,
    input  in_ready, out_valid, out_opcode, level, partial, err_overflow
  );

  modport slave (
    input  in_valid, in_beat, out_ready,
    output in_ready, out_valid, out_opcode, level, partial, err_overflow
  );
endinterface

// File: rtl/gpu_opcode_collector.sv
// rtl/gpu_opcode_collector.sv - assembles opcodes from narrow beats into a show-ahead FIFO
module gpu_opcode_collector #(
  parameter int BEAT_W    = 4,
  parameter int OPCODE_W  = 16,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  gpu_opcode_collector_if.slave  bus
);
  localparam int BEATS = OPCODE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]    beat_cnt;
  logic [OPCODE_W-1:0] asm_q;
  logic [OPCODE_W-1:0] asm_next;
  logic [OPCODE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [LVL_W-1:0]    level_q;
  logic                err_q;

  logic last_beat;
  logic full;
  logic ready;
  logic accept;
  logic push;
  logic pop;

  assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));
  assign full      = (level_q == LVL_W'(DEPTH));
  // Only the final beat needs FIFO space; earlier beats just shift into asm_q.
  assign ready     = ~last_beat | ~full;
  assign accept    = bus.in_valid & ready & ~flush;
  assign push      = accept & last_beat;
  assign pop       = (level_q != '0) & bus.out_ready & ~flush;

  assign asm_next = MSB_FIRST ? {asm_q[OPCODE_W-BEAT_W-1:0], bus.in_beat}
                              : {bus.in_beat, asm_q[OPCODE_W-1:BEAT_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      asm_q    <= '0;
    end else if (flush) begin
      beat_cnt <= '0;
    end else if (accept) begin
      if (last_beat) begin
        beat_cnt <= '0;
      end else begin
        beat_cnt <= beat_cnt + CNT_W'(1);
        asm_q    <= asm_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= asm_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      level_q <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      level_q <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)      level_q <= level_q + LVL_W'(1);
      else if (pop && !push) level_q <= level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (flush) begin
      err_q <= 1'b0;
    end else if (bus.in_valid && !ready) begin
      err_q <= 1'b1;
    end
  end

  assign bus.in_ready     = ready;
  assign bus.out_valid    = (level_q != '0);
  // Gate the unreset RAM so the head reads as zero whenever the FIFO is empty.
  assign bus.out_opcode   = (level_q != '0) ? mem[head] : '0;
  assign bus.level        = level_q;
  assign bus.partial      = (beat_cnt != '0);
  assign bus.err_overflow = err_q;
endmodule

// File: tb/tb_gpu_opcode_collector.sv
// tb/tb_gpu_opcode_collector.sv - randomized and directed bench against a queue-based model
module tb_gpu_opcode_collector;
  localparam int BEAT_W   = 8;
  localparam int OPCODE_W = 16;
  localparam int DEPTH    = 4;
  localparam int BEATS    = OPCODE_W / BEAT_W;

  logic clk;
  logic rst_n;
  logic flush;

  gpu_opcode_collector_if #(.BEAT_W(8), .OPCODE_W(16), .DEPTH(4)) bus ();
  gpu_opcode_collector_if #(.BEAT_W(8), .OPCODE_W(16), .DEPTH(4)) bl ();
  gpu_opcode_collector_if #(.BEAT_W(4), .OPCODE_W(16), .DEPTH(4)) bn ();

  gpu_opcode_collector #(.BEAT_W(8), .OPCODE_W(16), .DEPTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
  );
  gpu_opcode_collector #(.BEAT_W(8), .OPCODE_W(16), .DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bl)
  );
  gpu_opcode_collector #(.BEAT_W(4), .OPCODE_W(16), .DEPTH(4), .MSB_FIRST(1'b1)) dut_nib (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mq[$];
  logic [7:0]  mb[BEATS];
  int          nb;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    nb    = 0;
    m_err = 1'b0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_valid"},   32'(bus.out_valid),    32'(mq.size() != 0));
    chk({tag, "_level"},   32'(bus.level),        32'(mq.size()));
    chk({tag, "_partial"}, 32'(bus.partial),      32'(nb != 0));
    chk({tag, "_err"},     32'(bus.err_overflow), 32'(m_err));
    chk({tag, "_opcode"},  32'(bus.out_opcode),   (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
  endtask

  // One clock: drive, check in_ready, advance the model, then check registered outputs.
  task automatic cycle(input bit v, input logic [7:0] b, input bit r, input bit f);
    bit          rdy_m;
    logic [15:0] w;
    bus.in_valid  = v;
    bus.in_beat   = b;
    bus.out_ready = r;
    flush         = f;
    #1;
    rdy_m = (nb != BEATS - 1) || (mq.size() != DEPTH);
    chk("in_ready", 32'(bus.in_ready), 32'(rdy_m));
    if (f) begin
      model_clear();
    end else begin
      if (r && mq.size() != 0) void'(mq.pop_front());
      if (v && !rdy_m) begin
        m_err = 1'b1;
      end else if (v) begin
        mb[nb] = b;
        if (nb == BEATS - 1) begin
          w = '0;
          for (int i = 0; i < BEATS; i++) w = (w << 8) | 16'(mb[i]);
          mq.push_back(w);
          nb = 0;
        end else begin
          nb++;
        end
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    chk_outputs("cyc");
  endtask

  task automatic push_op(input logic [15:0] op);
    cycle(1'b1, op[15:8], 1'b0, 1'b0);
    cycle(1'b1, op[7:0], 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_beat = '0; bus.out_ready = 1'b0;
    bl.in_valid  = 1'b0; bl.in_beat  = '0; bl.out_ready  = 1'b0;
    bn.in_valid  = 1'b0; bn.in_beat  = '0; bn.out_ready  = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset");
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Beat order and beat width variants.
    bl.in_valid = 1'b1; bl.in_beat = 8'hAB;
    bn.in_valid = 1'b1; bn.in_beat = 4'h1;
    @(posedge clk); #1;
    bl.in_beat = 8'hCD;
    bn.in_beat = 4'h2;
    @(posedge clk); #1;
    bl.in_valid = 1'b0;
    chk("lsb_valid", 32'(bl.out_valid), 32'd1);
    chk("lsb_opcode", 32'(bl.out_opcode), 32'h0000CDAB);
    bn.in_beat = 4'h3;
    @(posedge clk); #1;
    chk("nib_partial", 32'(bn.partial), 32'd1);
    bn.in_beat = 4'h4;
    @(posedge clk); #1;
    bn.in_valid = 1'b0;
    chk("nib_valid", 32'(bn.out_valid), 32'd1);
    chk("nib_opcode", 32'(bn.out_opcode), 32'h00001234);

    // Two beats form one MSB-first opcode.
    cycle(1'b1, 8'hAB, 1'b0, 1'b0);
    chk("t1_partial", 32'(bus.partial), 32'd1);
    cycle(1'b1, 8'hCD, 1'b0, 1'b0);
    chk("t1_opcode", 32'(bus.out_opcode), 32'h0000ABCD);
    chk("t1_level", 32'(bus.level), 32'd1);

    // Fill, overflow on the last beat, drain in order.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) push_op(16'(i * 16'h0101));
    chk("t3_level_full", 32'(bus.level), 32'd4);
    cycle(1'b1, 8'h05, 1'b0, 1'b0);
    chk("t3_ready_low", 32'(bus.in_ready), 32'd0);
    cycle(1'b1, 8'h06, 1'b0, 1'b0);
    chk("t3_err", 32'(bus.err_overflow), 32'd1);
    chk("t3_level_hold", 32'(bus.level), 32'd4);
    chk("t3_head", 32'(bus.out_opcode), 32'h00000101);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_ready_back", 32'(bus.in_ready), 32'd1);
    cycle(1'b1, 8'h06, 1'b0, 1'b0);
    begin
      logic [15:0] exp3 [4];
      exp3[0] = 16'h0202; exp3[1] = 16'h0303; exp3[2] = 16'h0404; exp3[3] = 16'h0506;
      for (int i = 0; i < 4; i++) begin
        chk("t3_drain", 32'(bus.out_opcode), 32'(exp3[i]));
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
      end
    end
    chk("t3_empty", 32'(bus.out_valid), 32'd0);

    // Simultaneous push and pop at level 2.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    push_op(16'h1111);
    push_op(16'h2222);
    cycle(1'b1, 8'hBE, 1'b0, 1'b0);
    cycle(1'b1, 8'hEF, 1'b1, 1'b0);
    chk("t4_level", 32'(bus.level), 32'd2);
    chk("t4_head", 32'(bus.out_opcode), 32'h00002222);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t4_tail", 32'(bus.out_opcode), 32'h0000BEEF);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush discards a partial opcode and the beat presented alongside it.
    cycle(1'b1, 8'h77, 1'b0, 1'b0);
    cycle(1'b1, 8'h88, 1'b0, 1'b1);
    chk("t5_partial", 32'(bus.partial), 32'd0);
    chk("t5_level", 32'(bus.level), 32'd0);
    push_op(16'h1234);
    chk("t5_opcode", 32'(bus.out_opcode), 32'h00001234);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 63) == 0));
    end

    // Asynchronous reset mid-opcode with three queued entries.
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    push_op(16'h0A0A);
    push_op(16'h0B0B);
    push_op(16'h0C0C);
    cycle(1'b1, 8'h0D, 1'b0, 1'b0);
    chk("t6_pre_level", 32'(bus.level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk_outputs("t6_async");
    chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_op(16'hA55A);
    chk("t6_opcode", 32'(bus.out_opcode), 32'h0000A55A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gpu_opcode_collector.md
Name: gpu_opcode_collector

Overview:
Parametrised successor to the top-level opcode shift register. It assembles fixed-width GPU opcodes from narrow beats supplied by the RP2040 over a small pin bus. Completed opcodes are buffered in a show-ahead FIFO and handed to the core array over a valid/ready handshake. It adds the following behaviour that the current shift register lacks:
- beat counting and opcode framing
- selectable beat order
- back-pressure
- flush
- sticky overflow detection
- fill-level reporting

Parameters:
BEAT_W, 4, bits per input beat.
OPCODE_W, 16, opcode width. Must be an integer multiple of BEAT_W, with BEATS = OPCODE_W/BEAT_W >= 2.
DEPTH, 4, FIFO entries. Must be a power of 2 and >= 2.
MSB_FIRST, 1, 1 = first beat lands in the opcode MSBs; 0 = first beat lands in the LSBs.

Ports:
clk  in  1  single clock; all state on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
flush  in  1  synchronous clear of the partial opcode, FIFO and error flag.
in_valid  in  1  a beat is presented.
in_ready  out  1  the beat can be accepted this cycle.
in_beat  in  BEAT_W  beat data.
out_valid  out  1  FIFO head holds an opcode.
out_ready  in  1  consumer takes the head this cycle.
out_opcode  out  OPCODE_W  FIFO head; stable while out_valid=1 and out_ready=0.
level  out  $clog2(DEPTH+1)  number of opcodes in the FIFO.
partial  out  1  beat counter != 0, i.e. an opcode is half-assembled.
err_overflow  out  1  sticky: a beat was presented while in_ready=0.

Behaviour:
- Reset (rst_n=0, async):
  - beat_cnt=0, assembly register=0, FIFO pointers=0.
  - Outputs: out_valid=0, level=0, partial=0, err_overflow=0, out_opcode=0.
  - in_ready=1, since it is combinational from beat_cnt=0.
  - Storage RAM contents need not be reset.
- Beat accept: a beat is accepted on in_valid & in_ready.
- Assembly, beats 0..BEATS-2:
  - MSB_FIRST=1: asm <= {asm[OPCODE_W-BEAT_W-1:0], in_beat}.
  - MSB_FIRST=0: asm <= {in_beat, asm[OPCODE_W-1:BEAT_W]}.
  - beat_cnt increments.
- Last beat (beat_cnt==BEATS-1):
  - The word formed with the current beat is written into the FIFO tail in the same cycle.
  - beat_cnt wraps to 0.
  - The assembly register need not be cleared.
- in_ready = (beat_cnt != BEATS-1) | (level != DEPTH).
  - It does not depend on out_ready (no combinational path between the two handshakes).
  - Non-final beats are always accepted, even when the FIFO is full.
- Latency: last beat accepted in cycle N -> out_valid=1 and out_opcode valid in cycle N+1 when the FIFO was empty. The FIFO has no bypass.
- Pop: on out_valid & out_ready the head pointer advances; the next entry (or out_valid=0) appears the following cycle.
- Simultaneous push and pop: level unchanged and order preserved. This includes level=1, where the head is replaced by the new word the next cycle.
- Full: level==DEPTH. A push cannot occur because in_ready=0 on the last beat; a pop in the same cycle raises in_ready only in the next cycle.
- Pointers: $clog2(DEPTH) bits with wrap-around. level is kept as an explicit counter: +1 on push only, -1 on pop only.
- Overflow: in_valid & ~in_ready sets err_overflow=1. The beat is dropped and beat_cnt, asm and FIFO are unchanged. The flag holds until flush or reset.
- flush=1 has highest priority, in the next cycle:
  - beat_cnt=0, FIFO emptied (level=0, out_valid=0), err_overflow=0.
  - Any beat or pop presented in the flush cycle is ignored; the consumer must not treat a flush-cycle pop as taken.
- Async reset mid-opcode or with a full FIFO: all state clears immediately, with no partial word surviving.
- partial = (beat_cnt != 0), registered state.

Test Plan (BEAT_W=8, OPCODE_W=16, DEPTH=4, MSB_FIRST=1 unless stated):
1. Beats 0xAB, 0xCD with out_ready=0 -> one cycle after the 2nd beat: out_valid=1, out_opcode=0xABCD, level=1, partial=0. partial=1 between the two beats.
2. MSB_FIRST=0, same beats -> out_opcode=0xCDAB. With BEAT_W=4, OPCODE_W=16, beats 1,2,3,4 -> 0x1234 (MSB_FIRST=1).
3. out_ready=0, push 4 opcodes 0x0101..0x0404 -> level=4.
   - 5th opcode: 1st beat 0x05 accepted; with beat_cnt=1, in_ready=0.
   - Drive 0x06 anyway -> err_overflow=1, level=4, and 0x06 is discarded.
   - Pop once -> next cycle in_ready=1; beat 0x06 is then accepted.
   - Pop all -> 0x0101, 0x0202, 0x0303, 0x0404, 0x0506, in order.
4. level=2 with a simultaneous last-beat push (0xBEEF) and pop -> level stays 2, and subsequent pops deliver the remaining entries in order followed by 0xBEEF.
5. Send beat 0x77, then flush=1 with in_valid=1, in_beat=0x88 -> next cycle partial=0, level=0, err_overflow=0. Then beats 0x12, 0x34 -> out_opcode=0x1234.
6. Assert rst_n=0 asynchronously between clock edges with level=3 and partial=1 -> out_valid, level, partial and err_overflow drop to 0 before the next edge. After release, beats 0xA5, 0x5A -> 0xA55A.
